// File: rtl/bus_arbiter.sv
// Two-master round-robin bus arbiter with a bounded hold limit.
// Forwards the owner's command to the Bus and registers read data back to the owner.
module bus_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m1_req,
  input  logic        m0_wen,
  input  logic        m1_wen,
  input  logic        m0_ren,
  input  logic        m1_ren,
  input  logic        m0_wordorbyte,
  input  logic        m1_wordorbyte,
  input  logic        m0_sysuse,
  input  logic        m1_sysuse,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m0_wdata,
  input  logic [31:0] m1_wdata,
  output logic        m0_gnt,
  output logic        m1_gnt,
  output logic [31:0] m0_rdata,
  output logic [31:0] m1_rdata,
  output logic        m0_rvalid,
  output logic        m1_rvalid,
  output logic        bus_Write_enable,
  output logic        bus_Read_enable,
  output logic        bus_WordorByte,
  output logic        bus_SystemUse,
  output logic [31:0] bus_Addr,
  output logic [31:0] bus_Write_data,
  input  logic [31:0] bus_Read_data
);

  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          last_q, last_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          xfer0_s, xfer1_s, contend_s;
  logic          rvalid0_q, rvalid1_q;
  logic [31:0]   rdata0_q, rdata1_q;

  // State, priority pointer and hold counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
    end
  end

  // Next-state selection: tie goes to the master that did not own last
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (m0_req && m1_req)  state_d = last_q ? OWN0 : OWN1;
        else if (m0_req)       state_d = OWN0;
        else if (m1_req)       state_d = OWN1;
        else                   state_d = IDLE;
      end
      OWN0: begin
        if (!m0_req)                           state_d = m1_req ? OWN1 : IDLE;
        else if (m1_req && hold_q == HOLD_LAST) state_d = OWN1;
        else                                   state_d = OWN0;
      end
      OWN1: begin
        if (!m1_req)                           state_d = m0_req ? OWN0 : IDLE;
        else if (m0_req && hold_q == HOLD_LAST) state_d = OWN0;
        else                                   state_d = OWN1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Tenure bookkeeping: hold counts contended transfers only, saturating
  always_comb begin
    last_d    = last_q;
    hold_d    = hold_q;
    contend_s = (xfer0_s && m1_req) || (xfer1_s && m0_req);
    if (state_d != state_q) begin
      hold_d = '0;
      if (state_d == OWN0)      last_d = 1'b0;
      else if (state_d == OWN1) last_d = 1'b1;
      else                      last_d = last_q;
    end else if (contend_s && hold_q != HOLD_LAST) begin
      hold_d = hold_q + HW'(1);
    end else begin
      hold_d = hold_q;
    end
  end

  // Grant decode and Bus forwarding; strobes are blanked outside transfers
  always_comb begin
    m0_gnt           = (state_q == OWN0);
    m1_gnt           = (state_q == OWN1);
    xfer0_s          = (state_q == OWN0) && m0_req;
    xfer1_s          = (state_q == OWN1) && m1_req;
    bus_Write_enable = 1'b0;
    bus_Read_enable  = 1'b0;
    bus_WordorByte   = 1'b0;
    bus_SystemUse    = 1'b0;
    bus_Addr         = 32'h0000_0000;
    bus_Write_data   = 32'h0000_0000;
    if (xfer0_s) begin
      bus_Write_enable = m0_wen;
      bus_Read_enable  = m0_ren;
      bus_WordorByte   = m0_wordorbyte;
      bus_SystemUse    = m0_sysuse;
      bus_Addr         = m0_addr;
      bus_Write_data   = m0_wdata;
    end else if (xfer1_s) begin
      bus_Write_enable = m1_wen;
      bus_Read_enable  = m1_ren;
      bus_WordorByte   = m1_wordorbyte;
      bus_SystemUse    = m1_sysuse;
      bus_Addr         = m1_addr;
      bus_Write_data   = m1_wdata;
    end else begin
      bus_Write_enable = 1'b0;
    end
  end

  // Read return: capture at the end of the read transfer, pulse rvalid once
  always_ff @(posedge clk) begin
    if (reset) begin
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= 32'h0000_0000;
      rdata1_q  <= 32'h0000_0000;
    end else begin
      rvalid0_q <= xfer0_s && m0_ren;
      rvalid1_q <= xfer1_s && m1_ren;
      if (xfer0_s && m0_ren) rdata0_q <= bus_Read_data;
      if (xfer1_s && m1_ren) rdata1_q <= bus_Read_data;
    end
  end

  assign m0_rvalid = rvalid0_q;
  assign m1_rvalid = rvalid1_q;
  assign m0_rdata  = rdata0_q;
  assign m1_rdata  = rdata1_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: stimulus queues per-cycle and read-return
// expectations, a negedge monitor compares them against the DUT.
module tb_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m1_req, m0_wen, m1_wen, m0_ren, m1_ren;
  logic        m0_wordorbyte, m1_wordorbyte, m0_sysuse, m1_sysuse;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        bus_Write_enable, bus_Read_enable, bus_WordorByte, bus_SystemUse;
  logic [31:0] bus_Addr, bus_Write_data, bus_Read_data;

  bus_arbiter #(.MAX_HOLD(8)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m1_req(m1_req), .m0_wen(m0_wen), .m1_wen(m1_wen),
    .m0_ren(m0_ren), .m1_ren(m1_ren),
    .m0_wordorbyte(m0_wordorbyte), .m1_wordorbyte(m1_wordorbyte),
    .m0_sysuse(m0_sysuse), .m1_sysuse(m1_sysuse),
    .m0_addr(m0_addr), .m1_addr(m1_addr), .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
    .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
    .bus_Write_enable(bus_Write_enable), .bus_Read_enable(bus_Read_enable),
    .bus_WordorByte(bus_WordorByte), .bus_SystemUse(bus_SystemUse),
    .bus_Addr(bus_Addr), .bus_Write_data(bus_Write_data), .bus_Read_data(bus_Read_data)
  );

  always #5 clk = ~clk;

  // Bus model: preloaded DataMemory plus a writable BCD register
  logic [31:0] dmem [0:511];
  logic [31:0] bcd_r;

  always_comb begin
    if (bus_Addr < 32'h0000_0800)       bus_Read_data = dmem[bus_Addr[10:2]];
    else if (bus_Addr == 32'h4000_0010) bus_Read_data = bcd_r;
    else                                bus_Read_data = 32'h0000_0000;
  end

  always @(posedge clk)
    if (bus_Write_enable && bus_Addr == 32'h4000_0010) bcd_r <= bus_Write_data;

  typedef struct {
    string       nm;
    logic [1:0]  g;
    logic [3:0]  strb;
    logic [31:0] addr;
    logic [31:0] wd;
    bit          rst;
    int          idx;
  } exp_t;

  typedef struct {
    logic [31:0] d;
    int          idx;
  } rd_t;

  exp_t exp_q[$];
  rd_t  rq0[$];
  rd_t  rq1[$];
  int   step_n = 0;
  bit   done = 1'b0;
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Queue this cycle's expectations, then advance to just after the next edge.
  // g: {m1_gnt, m0_gnt}; xfer: master whose command should appear on the Bus (-1 none).
  task automatic step(input string nm, input logic [1:0] g, input int xfer,
                      input logic [31:0] rexp, input bit rst_chk);
    exp_t e;
    e.nm = nm; e.g = g; e.rst = rst_chk; e.idx = step_n;
    e.strb = 4'h0; e.addr = 32'h0; e.wd = 32'h0;
    if (xfer == 0) begin
      e.strb = {m0_wen, m0_ren, m0_wordorbyte, m0_sysuse};
      e.addr = m0_addr; e.wd = m0_wdata;
      if (m0_ren && !reset) rq0.push_back('{rexp, step_n});
    end else if (xfer == 1) begin
      e.strb = {m1_wen, m1_ren, m1_wordorbyte, m1_sysuse};
      e.addr = m1_addr; e.wd = m1_wdata;
      if (m1_ren && !reset) rq1.push_back('{rexp, step_n});
    end
    exp_q.push_back(e);
    step_n++;
    @(posedge clk);
    #1;
  endtask

  // Monitor: per-cycle grant/Bus checks and read-return scoreboard
  always @(negedge clk) begin
    exp_t e;
    rd_t  r;
    int   cur;
    cur = -1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      cur = e.idx;
      chk({e.nm, "_gnt"}, {30'd0, m1_gnt, m0_gnt}, {30'd0, e.g});
      chk({e.nm, "_strobes"},
          {28'd0, bus_Write_enable, bus_Read_enable, bus_WordorByte, bus_SystemUse},
          {28'd0, e.strb});
      chk({e.nm, "_addr"}, bus_Addr, e.addr);
      chk({e.nm, "_wdata"}, bus_Write_data, e.wd);
      if (e.rst) begin
        chk({e.nm, "_rvalid"}, {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
        chk({e.nm, "_m0_rdata"}, m0_rdata, 32'd0);
        chk({e.nm, "_m1_rdata"}, m1_rdata, 32'd0);
      end
    end
    if (m0_rvalid === 1'b1) begin
      if (rq0.size() == 0) chk("m0_rvalid_unexpected", 32'd1, 32'd0);
      else begin
        r = rq0.pop_front();
        chk("m0_rdata", m0_rdata, r.d);
        chk("m0_rvalid_cycle", cur, r.idx + 1);
      end
    end
    if (m1_rvalid === 1'b1) begin
      if (rq1.size() == 0) chk("m1_rvalid_unexpected", 32'd1, 32'd0);
      else begin
        r = rq1.pop_front();
        chk("m1_rdata", m1_rdata, r.d);
        chk("m1_rvalid_cycle", cur, r.idx + 1);
      end
    end
    if (done && exp_q.size() == 0) begin
      chk("m0_reads_outstanding", rq0.size(), 32'd0);
      chk("m1_reads_outstanding", rq1.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  initial begin
    for (int i = 0; i < 512; i++) dmem[i] = 32'h0000_0000;
    dmem[1] = 32'h1234_5678;
    dmem[2] = 32'hCAFE_F00D;
    reset = 1'b1;
    m0_req = 1'b0; m1_req = 1'b0; m0_wen = 1'b0; m1_wen = 1'b0;
    m0_ren = 1'b0; m1_ren = 1'b0; m0_wordorbyte = 1'b0; m1_wordorbyte = 1'b0;
    m0_sysuse = 1'b0; m1_sysuse = 1'b0;
    m0_addr = 32'h0; m1_addr = 32'h0; m0_wdata = 32'h0; m1_wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    step("reset_idle", 2'b00, -1, 32'h0, 1'b1);

    // m0 single read from IDLE
    m0_req = 1'b1; m0_ren = 1'b1; m0_addr = 32'h0000_0004;
    step("m0_req_idle", 2'b00, -1, 32'h0, 1'b0);
    step("m0_read", 2'b01, 0, 32'h1234_5678, 1'b0);
    m0_req = 1'b0; m0_ren = 1'b0;
    step("m0_release", 2'b01, -1, 32'h0, 1'b0);
    step("m0_idle_after", 2'b00, -1, 32'h0, 1'b0);

    // Fresh reset, simultaneous requests: m0 first, then m1 on the next tie
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    m0_req = 1'b1; m1_req = 1'b1;
    step("tie_idle", 2'b00, -1, 32'h0, 1'b1);
    step("tie_m0", 2'b01, 0, 32'h0, 1'b0);
    m0_req = 1'b0; m1_req = 1'b0;
    step("tie_drop", 2'b01, -1, 32'h0, 1'b0);
    m0_req = 1'b1; m1_req = 1'b1; m0_ren = 1'b1; m1_ren = 1'b1;
    m0_addr = 32'h0000_0004; m1_addr = 32'h0000_0008;
    step("tie_idle2", 2'b00, -1, 32'h0, 1'b0);

    // Continuous contention: 8 transfers per owner, starting with m1
    for (int k = 0; k < 24; k++) begin
      if (((k / 8) % 2) == 0) step("fair_m1", 2'b10, 1, 32'hCAFE_F00D, 1'b0);
      else                    step("fair_m0", 2'b01, 0, 32'h1234_5678, 1'b0);
    end
    m0_req = 1'b0; m1_req = 1'b0; m0_ren = 1'b0; m1_ren = 1'b0;
    step("fair_drop", 2'b01, -1, 32'h0, 1'b0);

    // m1 writes the BCD register then reads it back
    m1_req = 1'b1; m1_wen = 1'b1; m1_addr = 32'h4000_0010; m1_wdata = 32'h0000_ABCD;
    m1_wordorbyte = 1'b1; m1_sysuse = 1'b1;
    step("wr_idle", 2'b00, -1, 32'h0, 1'b0);
    step("m1_write", 2'b10, 1, 32'h0, 1'b0);
    m1_wen = 1'b0; m1_ren = 1'b1;
    step("m1_read", 2'b10, 1, 32'h0000_ABCD, 1'b0);
    m1_req = 1'b0; m1_ren = 1'b0;
    step("m1_release", 2'b10, -1, 32'h0, 1'b0);

    // Reset asserted during an m1 read transfer
    m1_req = 1'b1; m1_ren = 1'b1; m1_addr = 32'h0000_0008;
    m1_wordorbyte = 1'b0; m1_sysuse = 1'b0; m1_wdata = 32'h0;
    step("rst_req_idle", 2'b00, -1, 32'h0, 1'b0);
    reset = 1'b1;
    step("rst_during_read", 2'b10, 1, 32'h0, 1'b0);
    reset = 1'b0; m1_req = 1'b0; m1_ren = 1'b0;
    step("after_reset", 2'b00, -1, 32'h0, 1'b1);
    step("final_idle", 2'b00, -1, 32'h0, 1'b0);
    done = 1'b1;
    #1000;
    $display("FAIL monitor_timeout actual=running required=finished");
    $fatal(1, "bench did not reach summary");
  end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Two-master arbiter in front of the memory-mapped Bus (DataMemory below 0x800, BCD register 0x40000010, system counter 0x40000014). Master 0 is the CPU data port and master 1 is a secondary requester (boot loader / DMA). The arbiter grants bus ownership round-robin and bounds each tenure with a hold limit. It forwards the owner's command to the Bus, registers read data back to the owner, and blanks all Bus strobes when no transfer is in progress.

## Interface
- MAX_HOLD, 8: maximum consecutive transfer cycles an owner keeps the bus while the other master is requesting (≥1).
- clk  in  1  system clock; all state on rising edge
- reset  in  1  synchronous, active-high reset
- m0_req, m1_req  in  1  master requests a transfer this cycle
- m0_wen, m1_wen  in  1  write strobe
- m0_ren, m1_ren  in  1  read strobe
- m0_wordorbyte, m1_wordorbyte  in  1  word/byte select, forwarded unchanged
- m0_sysuse, m1_sysuse  in  1  system-use flag, forwarded unchanged
- m0_addr, m1_addr  in  32  byte address
- m0_wdata, m1_wdata  in  32  write data
- m0_gnt, m1_gnt  out  1  master owns the bus this cycle
- m0_rdata, m1_rdata  out  32  registered read data
- m0_rvalid, m1_rvalid  out  1  one-cycle pulse: rdata updated
- bus_Write_enable, bus_Read_enable, bus_WordorByte, bus_SystemUse  out  1  to Bus
- bus_Addr, bus_Write_data  out  32  to Bus
- bus_Read_data  in  32  combinational read data from Bus

## Operation
- FSM states: IDLE, OWN0, OWN1. `mX_gnt = (state == OWNX)`, decoded from registered state.
- A transfer occurs in a cycle where `state == OWNX && mX_req`. In that cycle all bus_* outputs equal master X's fields. In every other cycle all bus_* outputs are 0.
- Priority pointer `last` (1 bit) records the most recent owner. Tie-break on a simultaneous request goes to `!last`.
- IDLE:
  - Only m0_req → OWN0; only m1_req → OWN1.
  - Both → OWN(!last).
  - Neither → stay IDLE.
- OWNX:
  - If mX_req is low: other master requesting → OWN(other); else → IDLE.
  - If mX_req is high, other master requesting and hold_cnt == MAX_HOLD-1 → OWN(other).
  - Otherwise stay in OWNX.
- On entering OWNX, set `last = X`.
- hold_cnt is a $clog2(MAX_HOLD+1)-bit counter:
  - clears on every state change;
  - increments on each transfer cycle while the other master is requesting;
  - saturates at MAX_HOLD-1.
- Read return:
  - A transfer with mX_ren=1 captures bus_Read_data into mX_rdata at the end of that cycle and sets mX_rvalid=1 for the next cycle only.
  - mX_rdata holds its value until the next read by that master.
- Writes have no response. A write is complete in its transfer cycle.
- wen and ren both high: both are forwarded (Bus semantics apply). Read data is still returned.

## Timing
- Reset values: state IDLE, last=1 (m0 wins the first tie), hold_cnt=0. All gnt, rvalid and bus_* outputs are 0, and both rdata=0.
- Grant latency from IDLE: request at cycle N → gnt at N+1 → first transfer at N+1.
- Back-to-back transfers by the owner: one per cycle, no bubbles.
- Read latency: transfer at cycle N → rvalid/rdata at N+1.
- Handover costs 0 bubble cycles: the new owner is granted in the cycle after the switch decision. A master must hold req and command stable until it sees gnt.
- Fairness: while both request continuously, the grant alternates after exactly MAX_HOLD transfers each.
- Reset mid-transfer: the next cycle is IDLE with all outputs at reset values. A pending rvalid is suppressed.
- MAX_HOLD=1: strict alternation under contention.

## Test plan
- After reset, hold m0_req=1 with a read of 0x00000004 (DataMemory holds 0x12345678) → m0_gnt=1 from cycle 1, bus_Read_enable=1 with bus_Addr=0x4, and m0_rvalid pulses with m0_rdata=0x12345678 in cycle 2.
- m0 and m1 request in the same cycle from IDLE after reset → OWN0 first. Both requesting again after m0 releases → m1 granted.
- Both request continuously with MAX_HOLD=8 → gnt sequence is 8 cycles m0, 8 cycles m1, repeating. The two gnt signals are never high together.
- m1 writes 0x0000ABCD to 0x40000010 while m0 is idle → bus_Write_enable=1 with bus_Addr=0x40000010 for one cycle. A following m1 read returns 0x0000ABCD.
- Owner drops req with no other requester → IDLE next cycle. All bus_* outputs are 0 while idle or while the owner's req is low.
- Assert reset in the same cycle as an m1 read transfer → next cycle all gnt/rvalid are 0, both rdata=0, state IDLE.
